// File: rtl/tpu_tile_sequencer.sv
// Tile sequencer for an ARR x ARR systolic array: walks output tiles and drives
// A/B read indices, PE clear/feed strobes and C write-back indices for one matmul.
module tpu_tile_sequencer #(
  parameter int ARR   = 4,
  parameter int IDX_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [7:0]               K,
  input  logic [7:0]               M,
  input  logic [7:0]               N,
  output logic                     busy,
  output logic                     done,
  output logic [IDX_W-1:0]         a_index,
  output logic [IDX_W-1:0]         b_index,
  output logic                     pe_clear,
  output logic                     pe_feed_valid,
  output logic                     c_wr_en,
  output logic [IDX_W-1:0]         c_index,
  output logic [$clog2(ARR)-1:0]   c_row_sel
);

  localparam int RW = $clog2(ARR);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FEED,
    S_DRAIN,
    S_WRITE,
    S_DONE
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [6:0] mt_q, mt_d, nt_q, nt_d;
  logic [7:0] k_len, m_len;
  logic [6:0] mt_num, nt_num;
  logic [8:0] m_ceil, n_ceil;

  logic [IDX_W-1:0] row_d;
  logic [IDX_W-1:0] a_index_d, b_index_d, c_index_d;
  logic             busy_d, done_d, pe_clear_d, c_wr_en_d;
  logic [RW-1:0]    c_row_sel_d;

  assign m_ceil = {1'b0, M} + 9'(ARR - 1);
  assign n_ceil = {1'b0, N} + 9'(ARR - 1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mt_d    = mt_q;
    nt_d    = nt_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          cnt_d   = '0;
          mt_d    = '0;
          nt_d    = '0;
          state_d = (K == '0 || M == '0 || N == '0) ? S_DONE : S_FEED;
        end
      end
      S_FEED: begin
        if (cnt_q == k_len - 8'd1) begin
          cnt_d   = '0;
          state_d = S_DRAIN;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DRAIN: begin
        if (cnt_q == 8'(2 * ARR - 1)) begin
          cnt_d   = '0;
          state_d = S_WRITE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_WRITE: begin
        if (cnt_q == 8'(ARR - 1)) begin
          cnt_d = '0;
          if (nt_q == nt_num - 7'd1) begin
            nt_d = '0;
            if (mt_q == mt_num - 7'd1) begin
              state_d = S_DONE;
            end else begin
              mt_d    = mt_q + 7'd1;
              state_d = S_FEED;
            end
          end else begin
            nt_d    = nt_q + 7'd1;
            state_d = S_FEED;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are derived from the next state so they appear registered in the
  // same cycle the FSM enters the state (k_len is stale only when mt_d is 0).
  always_comb begin
    row_d       = IDX_W'(mt_d) * IDX_W'(ARR) + IDX_W'(cnt_d);
    a_index_d   = a_index;
    b_index_d   = b_index;
    c_index_d   = c_index;
    c_wr_en_d   = 1'b0;
    c_row_sel_d = '0;
    pe_clear_d  = 1'b0;
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    if (state_d == S_FEED) begin
      a_index_d  = IDX_W'(mt_d) * IDX_W'(k_len) + IDX_W'(cnt_d);
      b_index_d  = IDX_W'(nt_d) * IDX_W'(k_len) + IDX_W'(cnt_d);
      pe_clear_d = (cnt_d == '0);
    end
    if (state_d == S_WRITE) begin
      c_index_d   = row_d * IDX_W'(nt_num) + IDX_W'(nt_d);
      c_wr_en_d   = (row_d < IDX_W'(m_len));
      c_row_sel_d = RW'(cnt_d);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      mt_q          <= '0;
      nt_q          <= '0;
      k_len         <= '0;
      m_len         <= '0;
      mt_num        <= '0;
      nt_num        <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      a_index       <= '0;
      b_index       <= '0;
      pe_clear      <= 1'b0;
      pe_feed_valid <= 1'b0;
      c_wr_en       <= 1'b0;
      c_index       <= '0;
      c_row_sel     <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      mt_q          <= mt_d;
      nt_q          <= nt_d;
      if (state_q == S_IDLE && in_valid) begin
        k_len  <= K;
        m_len  <= M;
        mt_num <= 7'(m_ceil >> RW);
        nt_num <= 7'(n_ceil >> RW);
      end
      busy          <= busy_d;
      done          <= done_d;
      a_index       <= a_index_d;
      b_index       <= b_index_d;
      pe_clear      <= pe_clear_d;
      pe_feed_valid <= (state_q == S_FEED);
      c_wr_en       <= c_wr_en_d;
      c_index       <= c_index_d;
      c_row_sel     <= c_row_sel_d;
    end
  end

endmodule

// File: tb/tb_tpu_tile_sequencer.sv
// Scoreboard bench for tpu_tile_sequencer: the driver queues expected reads,
// writes and job lengths; a negedge monitor pops and compares them.
module tb_tpu_tile_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  K = '0, M = '0, N = '0;
  logic        busy, done, pe_clear, pe_feed_valid, c_wr_en;
  logic [15:0] a_index, b_index, c_index;
  logic [1:0]  c_row_sel;

  tpu_tile_sequencer #(.ARR(4), .IDX_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .K(K), .M(M), .N(N),
    .busy(busy), .done(done), .a_index(a_index), .b_index(b_index),
    .pe_clear(pe_clear), .pe_feed_valid(pe_feed_valid), .c_wr_en(c_wr_en),
    .c_index(c_index), .c_row_sel(c_row_sel)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned t;
    logic [15:0] a;
    logic [15:0] b;
    logic        clr;
  } rd_t;

  typedef struct {
    int unsigned t;
    logic [15:0] c;
    logic [1:0]  row;
  } wr_t;

  rd_t         rd_q[$];
  wr_t         wr_q[$];
  int unsigned done_q[$];
  int unsigned wc_q[$];

  int          checks = 0;
  int          errors = 0;
  int unsigned done_cnt = 0;
  logic        timeout_flag = 1'b0;

  // monitor-private state
  int unsigned busy_cnt = 0, wr_seen = 0, p_t = 0, exp_len = 0, exp_wc = 0;
  logic [15:0] p_a = '0, p_b = '0;
  logic        p_clr = 1'b0, p_done = 1'b0, to_seen = 1'b0;
  rd_t         er;
  wr_t         ew;

  always @(negedge clk) begin
    if (!rst_n) begin
      checks++;
      if ({busy, done, pe_clear, pe_feed_valid, c_wr_en, c_row_sel, a_index, b_index, c_index} !== '0) begin
        errors++;
        $display("FAIL reset_outputs got busy=%b done=%b clr=%b fv=%b wr=%b row=%0d a=%0d b=%0d c=%0d want all 0",
                 busy, done, pe_clear, pe_feed_valid, c_wr_en, c_row_sel, a_index, b_index, c_index);
      end
      rd_q.delete(); wr_q.delete(); done_q.delete(); wc_q.delete();
      busy_cnt = 0; wr_seen = 0; p_clr = 1'b0; p_done = 1'b0; p_t = 0;
    end else begin
      if (busy) busy_cnt++;
      if (p_done) begin
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL busy_after_done got %b want 0", busy);
        end
      end
      if (pe_feed_valid) begin
        checks++;
        if (rd_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_read got a=%0d b=%0d at cycle %0d want none", p_a, p_b, p_t);
        end else begin
          er = rd_q.pop_front();
          if (p_t != er.t || p_a !== er.a || p_b !== er.b || p_clr !== er.clr) begin
            errors++;
            $display("FAIL read got cyc=%0d a=%0d b=%0d clr=%b want cyc=%0d a=%0d b=%0d clr=%b",
                     p_t, p_a, p_b, p_clr, er.t, er.a, er.b, er.clr);
          end
        end
      end else if (p_clr) begin
        checks++;
        errors++;
        $display("FAIL stray_clear got clear at cycle %0d without feed want clear followed by feed", p_t);
      end
      if (c_wr_en) begin
        wr_seen++;
        checks++;
        if (wr_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write got c=%0d row=%0d at cycle %0d want none", c_index, c_row_sel, busy_cnt);
        end else begin
          ew = wr_q.pop_front();
          if (busy_cnt != ew.t || c_index !== ew.c || c_row_sel !== ew.row) begin
            errors++;
            $display("FAIL write got cyc=%0d c=%0d row=%0d want cyc=%0d c=%0d row=%0d",
                     busy_cnt, c_index, c_row_sel, ew.t, ew.c, ew.row);
          end
        end
      end
      if (done) begin
        checks++;
        if (done_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done got done at busy cycle %0d want none", busy_cnt);
        end else begin
          exp_len = done_q.pop_front();
          exp_wc  = wc_q.pop_front();
          if (busy_cnt != exp_len || wr_seen != exp_wc || rd_q.size() != 0 || wr_q.size() != 0) begin
            errors++;
            $display("FAIL job_end got busy=%0d writes=%0d left_rd=%0d left_wr=%0d want busy=%0d writes=%0d left 0/0",
                     busy_cnt, wr_seen, rd_q.size(), wr_q.size(), exp_len, exp_wc);
          end
        end
        done_cnt++;
        busy_cnt = 0;
        wr_seen  = 0;
      end
      if (timeout_flag && !to_seen) begin
        to_seen = 1'b1;
        checks++;
        errors++;
        $display("FAIL done_timeout got no done want done within budget");
      end
      p_a = a_index; p_b = b_index; p_clr = pe_clear; p_t = busy_cnt; p_done = done;
    end
  end

  task automatic start(input int unsigned k, input int unsigned m, input int unsigned n);
    @(posedge clk); #1;
    in_valid = 1'b1; K = 8'(k); M = 8'(m); N = 8'(n);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int unsigned budget);
    int unsigned d0;
    bit got;
    d0 = done_cnt;
    got = 1'b0;
    for (int unsigned i = 0; i < budget && !got; i++) begin
      @(posedge clk);
      if (done_cnt != d0) got = 1'b1;
    end
    if (!got) timeout_flag = 1'b1;
    #1;
  endtask

  // K=M=N=4: reads at cycles 1..4, writes at 13..16, done at 17
  task automatic push_scen1();
    rd_t r;
    wr_t w;
    for (int i = 0; i < 4; i++) begin
      r.t = 32'(i + 1); r.a = 16'(i); r.b = 16'(i); r.clr = (i == 0);
      rd_q.push_back(r);
      w.t = 32'(13 + i); w.c = 16'(i); w.row = 2'(i);
      wr_q.push_back(w);
    end
    done_q.push_back(17);
    wc_q.push_back(4);
  endtask

  task automatic push_job(input int unsigned k, input int unsigned m, input int unsigned n,
                          input int unsigned wc);
    int unsigned mtn, ntn, tile, base;
    rd_t r;
    wr_t w;
    if (k == 0 || m == 0 || n == 0) begin
      done_q.push_back(1);
      wc_q.push_back(wc);
      return;
    end
    mtn = (m + 3) / 4;
    ntn = (n + 3) / 4;
    tile = 0;
    for (int unsigned mt = 0; mt < mtn; mt++) begin
      for (int unsigned nt = 0; nt < ntn; nt++) begin
        base = tile * (k + 12);
        for (int unsigned kk = 0; kk < k; kk++) begin
          r.t = base + kk + 1; r.a = 16'(mt * k + kk); r.b = 16'(nt * k + kk); r.clr = (kk == 0);
          rd_q.push_back(r);
        end
        for (int unsigned rr = 0; rr < 4; rr++) begin
          if (mt * 4 + rr < m) begin
            w.t = base + k + 9 + rr; w.c = 16'((mt * 4 + rr) * ntn + nt); w.row = 2'(rr);
            wr_q.push_back(w);
          end
        end
        tile++;
      end
    end
    done_q.push_back(mtn * ntn * (k + 12) + 1);
    wc_q.push_back(wc);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    push_scen1();
    start(4, 4, 4);
    wait_done(100);

    // 4 rows x 2 tiles for mt=0 plus rows 4,5 x 2 tiles for mt=1
    push_job(3, 6, 8, 12);
    start(3, 6, 8);
    wait_done(200);

    push_job(0, 4, 4, 0);
    start(0, 4, 4);
    wait_done(20);

    push_job(2, 8, 8, 16);
    start(2, 8, 8);
    @(posedge clk); #1;
    in_valid = 1'b1; K = 8'd9; M = 8'd1; N = 8'd1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_done(200);

    // abort during DRAIN of tile 0
    push_scen1();
    start(4, 4, 4);
    repeat (6) @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    push_scen1();
    start(4, 4, 4);
    wait_done(100);

    // MT=64 with full K: last a_index 63*255+254
    push_job(255, 255, 1, 255);
    start(255, 255, 1);
    wait_done(20000);

    // 64x64 tiles: last c_index 254*64+63, row 255 skipped
    push_job(1, 255, 255, 16320);
    start(1, 255, 255);
    wait_done(60000);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
